// File: rtl/rf_hazard_ctrl.sv
// rtl/rf_hazard_ctrl.sv - scoreboard, forwarding selects and load-use stall for the 8x16 register file
// Optional stall-cycle counter port stall_cnt enabled by defining RF_HAZARD_PERF_EN.
module rf_hazard_ctrl #(
  parameter int NREG  = 8,
  parameter int DEPTH = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    dec_valid,
  input  logic [$clog2(NREG)-1:0] dec_ra,
  input  logic [$clog2(NREG)-1:0] dec_rb,
  input  logic                    dec_use_a,
  input  logic                    dec_use_b,
  input  logic                    dec_wr_en,
  input  logic [$clog2(NREG)-1:0] dec_dest,
  input  logic                    dec_is_load,
  input  logic                    flush,
  output logic                    stall,
  output logic [1:0]              fwd_a,
  output logic [1:0]              fwd_b,
  output logic                    dep_a,
`ifdef RF_HAZARD_PERF_EN
  output logic                    dep_b,
  output logic [15:0]             stall_cnt
`else
  output logic                    dep_b
`endif
);

  localparam int IW = $clog2(NREG);
  localparam int EX = 0;
  localparam int MEM = 1;
  localparam int WB = 2;

  typedef struct packed {
    logic          v;
    logic [IW-1:0] dest;
    logic          ld;
  } entry_t;

  // Stage entries after decode; the indexing below assumes DEPTH == 3.
  entry_t pipe [DEPTH];
  entry_t dec_entry;

  logic [2:0] sel_a;
  logic [2:0] sel_b;
  logic       lu_a;
  logic       lu_b;

  function automatic logic hit(input entry_t e, input logic [IW-1:0] s, input logic use_s,
                               input logic valid);
    return e.v && (e.dest == s) && use_s && (s != '0) && valid;
  endfunction

  // Returns {load_use, select}; the youngest matching stage wins.
  function automatic logic [2:0] op_sel(input entry_t ex, input entry_t mem, input entry_t wb,
                                        input logic [IW-1:0] s, input logic use_s,
                                        input logic valid);
    logic [2:0] r;
    r = 3'b000;
    if (hit(ex, s, use_s, valid)) begin
      if (ex.ld) r = 3'b100;
      else       r = 3'b001;
    end else if (hit(mem, s, use_s, valid)) begin
      r = 3'b010;
    end else if (hit(wb, s, use_s, valid)) begin
      r = 3'b011;
    end
    return r;
  endfunction

  assign sel_a = op_sel(pipe[EX], pipe[MEM], pipe[WB], dec_ra, dec_use_a, dec_valid);
  assign sel_b = op_sel(pipe[EX], pipe[MEM], pipe[WB], dec_rb, dec_use_b, dec_valid);

  assign lu_a  = sel_a[2];
  assign lu_b  = sel_b[2];
  assign fwd_a = sel_a[1:0];
  assign fwd_b = sel_b[1:0];
  assign dep_a = (fwd_a != 2'd0);
  assign dep_b = (fwd_b != 2'd0);
  assign stall = (lu_a || lu_b) && !flush;

  // R0 is the PC, so writes to it never occupy a scoreboard entry.
  assign dec_entry.v    = dec_valid && dec_wr_en && (dec_dest != '0);
  assign dec_entry.dest = dec_dest;
  assign dec_entry.ld   = dec_is_load;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe[EX]  <= '0;
      pipe[MEM] <= '0;
      pipe[WB]  <= '0;
    end else begin
      pipe[WB]  <= pipe[MEM];
      pipe[MEM] <= pipe[EX];
      if (flush || stall) pipe[EX] <= '0;
      else                pipe[EX] <= dec_entry;
    end
  end

`ifdef RF_HAZARD_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= 16'd0;
    end else if (stall && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/rf_hazard_ctrl.md
Name: rf_hazard_ctrl

Overview:
- Scoreboard and forwarding controller for the 8x16 register file in the 6-stage pipeline.
- Tracks in-flight destination registers through the EX, MEM and WB stages.
- Drives per-operand forwarding selects (the source of data_dep_sig1/2) and a load-use stall to the decode stage.
- Accepts a branch/jump flush. R0 is the PC and is never tracked.

Parameters:
- NREG, 8, number of architectural registers; index width is clog2(NREG)=3.
- DEPTH, 3, tracked stages after decode: EX=0, MEM=1, WB=2. Fixed at 3; other values unsupported.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-high reset
- dec_valid  in  1  decode stage holds a real instruction
- dec_ra  in  3  source A register index
- dec_rb  in  3  source B register index
- dec_use_a  in  1  instruction reads source A
- dec_use_b  in  1  instruction reads source B
- dec_wr_en  in  1  instruction writes a register
- dec_dest  in  3  destination register index
- dec_is_load  in  1  result comes from data memory (available at end of MEM)
- flush  in  1  branch/jump taken; kill decode and EX entries
- stall  out  1  hold fetch/decode, insert bubble into EX
- fwd_a  out  2  source A select: 0=regfile, 1=EX result, 2=MEM result, 3=WB data
- fwd_b  out  2  source B select, same encoding as fwd_a
- dep_a  out  1  fwd_a!=0 (drives data_dep_sig1)
- dep_b  out  1  fwd_b!=0 (drives data_dep_sig2)

Behaviour:
- State: three entries {v, dest[2:0], ld} for EX, MEM, WB. No other storage except the optional counter.
- Reset (async): all v=0 and the optional counter is 0. Outputs therefore read stall=0, fwd_a=fwd_b=0, dep_a=dep_b=0.
- Tracked entry on issue: v = dec_valid & dec_wr_en & (dec_dest!=0). A write to R0 is never tracked.
- Match for a source s, per stage: stage.v & (stage.dest==s) & use_s & (s!=0) & dec_valid.
- Forward select is the youngest match wins:
  - EX match and EX.ld: stall contribution; select value is don't-care, driven as 0.
  - EX match and not ld: 1.
  - else MEM match: 2.
  - else WB match: 3.
  - else: 0.
- stall = load-use match on A or B, and flush=0. Outputs are combinational from state and inputs, with zero-cycle latency, so they are valid before the same edge on which the register file samples operands.
- Clock edge update, in priority order:
  - flush=1: EX.v<=0, MEM<=EX, WB<=MEM. The decode instruction is discarded and stall is forced 0.
  - stall=1: EX.v<=0 (bubble), MEM<=EX, WB<=MEM. The decode instruction is held.
  - else: EX<=decode entry, MEM<=EX, WB<=MEM.
- WB entry retires on the next edge. Same-cycle WB write and decode read is covered by fwd=3, so the regfile write-before-read ordering is irrelevant.
- Load-use costs exactly 1 bubble. On the following cycle the load sits in MEM and forwarding selects 2.
- ra==rb with one match: fwd_a and fwd_b are both set identically.
- Simultaneous flush and load-use: flush wins and no stall is asserted.
- Reset mid-operation: all in-flight entries are dropped immediately. The first post-reset instruction sees no hazards.
- dec_valid=0: fwd_a=fwd_b=0, stall=0, and a bubble enters EX.

Optional Feature:
- Macro: RF_HAZARD_PERF_EN.
- Defined: adds output stall_cnt [15:0], a saturating count of cycles with stall=1. It is cleared by reset and holds at 16'hFFFF.
- Not defined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Back-to-back ALU hazard: issue write r3, then read ra=r3 next cycle -> fwd_a=1, dep_a=1, stall=0.
- Distance 2 and 3: write r5, one unrelated instruction, then read rb=r5 -> fwd_b=2. With two unrelated instructions in between -> fwd_b=3. With three -> fwd_b=0.
- Load-use: load to r2, then read ra=r2 -> stall=1 for exactly one cycle, then fwd_a=2 with stall=0. With the perf macro, stall_cnt=1.
- Youngest priority: write r4 (ALU) twice in consecutive cycles, then read r4 -> fwd=1, not 2. Read of r0 or a write to r0 -> fwd=0, never stall.
- Flush: load r1 in EX, decode reads r1, flush=1 -> stall=0. Next cycle EX.v=0 and a read of r1 gives fwd=2, from the load now in MEM.
- Async reset while a load sits in EX: assert reset between edges -> stall falls to 0 immediately and all fwd=0. The next instruction proceeds with no bubble.
